// File: rtl/parking_meter_pkg.sv
// Shared constants, display-state type and helper for the parking meter.
// Coin/preset values in seconds, LOW threshold, state classifier.
package parking_meter_pkg;

  localparam int TIME_W = 14;

  localparam logic [TIME_W-1:0] COIN1 = 14'd60;
  localparam logic [TIME_W-1:0] COIN2 = 14'd120;
  localparam logic [TIME_W-1:0] COIN3 = 14'd180;
  localparam logic [TIME_W-1:0] COIN4 = 14'd300;

  localparam logic [TIME_W-1:0] PRESET1 = 14'd15;
  localparam logic [TIME_W-1:0] PRESET2 = 14'd150;

  localparam logic [TIME_W-1:0] LOW_LIMIT = 14'd180;

  typedef enum logic [1:0] {
    ST_EXPIRED,
    ST_LOW,
    ST_OK
  } disp_state_t;

  function automatic disp_state_t disp_state(
    input logic [TIME_W-1:0] t
  );
    if (t == '0)
      return ST_EXPIRED;
    else if (t < LOW_LIMIT)
      return ST_LOW;
    else
      return ST_OK;
  endfunction

endpackage

// File: rtl/parking_meter_bcd_seg7.sv
// Binary seconds to four BCD digits plus active-low segments of one digit.
// Ports: bin (seconds), digit (0=units..3=thousands), d3..d0, seg.
module bcd_seg7
  import parking_meter_pkg::*;
(
  input  logic [TIME_W-1:0] bin,
  input  logic [1:0]        digit,
  output logic [3:0]        d3,
  output logic [3:0]        d2,
  output logic [3:0]        d1,
  output logic [3:0]        d0,
  output logic [6:0]        seg
);

  logic [15:0] bcd;
  logic [3:0]  cur;

  // Double dabble; inputs never exceed 9999 so 16 bits suffice.
  always_comb begin
    bcd = '0;
    for (int i = TIME_W - 1; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5)
          bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bin[i]};
    end
  end

  assign d3 = bcd[15:12];
  assign d2 = bcd[11:8];
  assign d1 = bcd[7:4];
  assign d0 = bcd[3:0];

  always_comb begin
    cur = d0;
    unique case (digit)
      2'd0: cur = d0;
      2'd1: cur = d1;
      2'd2: cur = d2;
      2'd3: cur = d3;
      default: cur = d0;
    endcase
  end

  // Segment order {g,f,e,d,c,b,a}, low = lit.
  always_comb begin
    seg = 7'h7F;
    unique case (cur)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/parking_meter_multi.sv
// Multi-space parking meter: per-space countdown, coins/presets, 4-digit scan.
// Ports: clk, rst(n), add1..4, rst1/2, space_sel, val1..4, led_seg, a1..4, expired.
module parking_meter_multi
  import parking_meter_pkg::*;
#(
  parameter int NUM_SPACES    = 2,
  parameter int TICKS_PER_SEC = 100,
  parameter int MAX_TIME      = 9999,
  parameter int SCAN_TICKS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  add1,
  input  logic                  add2,
  input  logic                  add3,
  input  logic                  add4,
  input  logic                  rst1,
  input  logic                  rst2,
  input  logic [1:0]            space_sel,
  output logic [3:0]            val1,
  output logic [3:0]            val2,
  output logic [3:0]            val3,
  output logic [3:0]            val4,
  output logic [6:0]            led_seg,
  output logic                  a1,
  output logic                  a2,
  output logic                  a3,
  output logic                  a4,
  output logic [NUM_SPACES-1:0] expired
);

  localparam int TICK_W =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SCAN_W =
    (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int SUM_W = TIME_W + 1;

  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TICK_W-1:0] TICK_HALF =
    TICK_W'(TICKS_PER_SEC / 2);
  localparam logic [SCAN_W-1:0] SCAN_LAST =
    SCAN_W'(SCAN_TICKS - 1);
  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_TIME);

  logic [TIME_W-1:0] times     [NUM_SPACES];
  logic [TIME_W-1:0] times_nxt [NUM_SPACES];
  logic [TICK_W-1:0] tick;
  logic              phase;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        scan_idx;
  logic [5:0]        btn_q;
  logic              armed;
  logic [3:0]        an;

  logic [5:0]        btn;
  logic [5:0]        rise;
  logic              sel_ok;
  logic              strobe;
  logic              ev_set;
  logic              ev_add;
  logic              hit;
  logic [TIME_W-1:0] ev_val;
  logic [TIME_W-1:0] sel_time;
  logic [6:0]        seg_raw;
  logic              blank;
  disp_state_t       state;

  assign btn = {rst1, rst2, add4, add3, add2, add1};

  // armed stays low for the first cycle after reset so a button
  // held through reset only gets captured, never fired.
  assign rise = btn & ~btn_q & {6{armed}};

  assign sel_ok = int'(space_sel) < NUM_SPACES;
  assign strobe = tick == TICK_LAST;

  always_comb begin
    ev_set = 1'b0;
    ev_add = 1'b0;
    ev_val = '0;
    priority case (1'b1)
      rise[5]: begin ev_set = 1'b1; ev_val = PRESET1; end
      rise[4]: begin ev_set = 1'b1; ev_val = PRESET2; end
      rise[3]: begin ev_add = 1'b1; ev_val = COIN4;   end
      rise[2]: begin ev_add = 1'b1; ev_val = COIN3;   end
      rise[1]: begin ev_add = 1'b1; ev_val = COIN2;   end
      rise[0]: begin ev_add = 1'b1; ev_val = COIN1;   end
      default: ;
    endcase
  end

  assign hit = sel_ok & (ev_set | ev_add);

  // Decrement first, then apply the event on top of it.
  always_comb begin
    logic [TIME_W-1:0] dec;
    logic [SUM_W-1:0]  sum;
    dec = '0;
    sum = '0;
    for (int k = 0; k < NUM_SPACES; k++) begin
      dec = times[k];
      if (strobe && times[k] != '0)
        dec = times[k] - 1'b1;
      sum = {1'b0, dec} + {1'b0, ev_val};
      times_nxt[k] = dec;
      if (hit && int'(space_sel) == k) begin
        if (ev_set)
          times_nxt[k] = ev_val;
        else if (sum > MAX_SUM)
          times_nxt[k] = MAX_SUM[TIME_W-1:0];
        else
          times_nxt[k] = sum[TIME_W-1:0];
      end
    end
  end

  always_comb begin
    sel_time = '0;
    for (int k = 0; k < NUM_SPACES; k++)
      if (int'(space_sel) == k)
        sel_time = times[k];
  end

  always_comb begin
    expired = '0;
    for (int k = 0; k < NUM_SPACES; k++)
      expired[k] = times[k] == '0;
  end

  bcd_seg7 u_bcd (
    .bin   (sel_time),
    .digit (scan_idx),
    .d3    (val1),
    .d2    (val2),
    .d1    (val3),
    .d0    (val4),
    .seg   (seg_raw)
  );

  assign state = disp_state(sel_time);

  always_comb begin
    blank = 1'b0;
    if (sel_ok) begin
      unique case (state)
        ST_OK:      blank = 1'b0;
        ST_LOW:     blank = phase;
        ST_EXPIRED: blank = tick >= TICK_HALF;
        default:    blank = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_SPACES; k++)
        times[k] <= '0;
      tick     <= '0;
      phase    <= 1'b0;
      scan_cnt <= '0;
      scan_idx <= '0;
      btn_q    <= '0;
      armed    <= 1'b0;
      an       <= 4'hF;
      led_seg  <= 7'h7F;
    end else begin
      for (int k = 0; k < NUM_SPACES; k++)
        times[k] <= times_nxt[k];
      btn_q <= btn;
      armed <= 1'b1;
      tick  <= strobe ? '0 : tick + 1'b1;
      if (strobe)
        phase <= ~phase;
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      // Anode and segments come from the same scan_idx, so they
      // always refer to the same digit.
      an      <= blank ? 4'hF : ~(4'b0001 << scan_idx);
      led_seg <= blank ? 7'h7F : seg_raw;
    end
  end

  assign {a1, a2, a3, a4} = an;

endmodule

// File: tb/tb_parking_meter_multi.sv
// Scoreboard bench for parking_meter_multi (2 spaces, 100 ticks/s).
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_parking_meter_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       add1 = 1'b0;
  logic       add2 = 1'b0;
  logic       add3 = 1'b0;
  logic       add4 = 1'b0;
  logic       rst1 = 1'b0;
  logic       rst2 = 1'b0;
  logic [1:0] space_sel = 2'd0;
  logic [3:0] val1, val2, val3, val4;
  logic [6:0] led_seg;
  logic       a1, a2, a3, a4;
  logic [1:0] expired;

  parking_meter_multi #(
    .NUM_SPACES    (2),
    .TICKS_PER_SEC (100),
    .MAX_TIME      (9999),
    .SCAN_TICKS    (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .add1      (add1),
    .add2      (add2),
    .add3      (add3),
    .add4      (add4),
    .rst1      (rst1),
    .rst2      (rst2),
    .space_sel (space_sel),
    .val1      (val1),
    .val2      (val2),
    .val3      (val3),
    .val4      (val4),
    .led_seg   (led_seg),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .a4        (a4),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  localparam int K_VAL   = 0;
  localparam int K_EXP   = 1;
  localparam int K_DISP  = 2;
  localparam int K_MARK  = 3;
  localparam int K_BLANK = 4;

  typedef struct {
    int    kind;
    string name;
    int    exp;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   blank_cnt = 0;
  int   cyc = 0;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  always @(negedge clk) begin
    chk_t c;
    int   act;
    if ({a1, a2, a3, a4} == 4'hF)
      blank_cnt++;
    while (q.size() > 0) begin
      c = q.pop_front();
      act = 0;
      if (c.kind == K_MARK) begin
        blank_cnt = 0;
      end else begin
        case (c.kind)
          K_VAL:   act = int'({val1, val2, val3, val4});
          K_EXP:   act = int'(expired);
          K_DISP:  act = int'({a1, a2, a3, a4, led_seg});
          default: act = blank_cnt;
        endcase
        checks++;
        if (act != c.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h",
                   c.name, act, c.exp);
        end
      end
    end
  end

  task automatic push(input int kind, input string name,
                      input int exp);
    chk_t c;
    c.kind = kind;
    c.name = name;
    c.exp  = exp;
    q.push_back(c);
  endtask

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      errors++;
      $display("FAIL goto: cycle %0d expected %0d", cyc, n);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    push(K_VAL, "rst_val", 'h0000);
    push(K_EXP, "rst_exp", 3);
    push(K_DISP, "rst_disp", 'h7FF);
    add1 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;

    goto(3);
    push(K_VAL, "held_btn", 'h0000);
    add1 = 1'b0;
    goto(4);
    add1 = 1'b1;
    goto(5);
    push(K_VAL, "add1", 'h0060);
    push(K_EXP, "add1_exp", 2);
    add1 = 1'b0;

    goto(300);
    push(K_MARK, "mark", 0);
    goto(350);
    push(K_DISP, "low_blank", 'h7FF);
    goto(450);
    push(K_DISP, "low_lit", int'({4'b1101, 7'h12}));
    goto(500);
    push(K_BLANK, "low_blink", 100);

    goto(705);
    push(K_VAL, "count_down", 'h0053);
    push(K_EXP, "count_exp", 2);
    add4 = 1'b1;
    add1 = 1'b1;
    goto(706);
    push(K_VAL, "add4_wins", 'h0353);
    push(K_EXP, "sp1_idle", 2);
    add4 = 1'b0;
    add1 = 1'b0;

    goto(707);
    push(K_DISP, "scan_h", int'({4'b1011, 7'h30}));
    goto(708);
    push(K_DISP, "scan_t", int'({4'b0111, 7'h40}));
    goto(709);
    push(K_DISP, "scan_u", int'({4'b1110, 7'h30}));
    goto(710);
    push(K_DISP, "scan_d", int'({4'b1101, 7'h12}));
    space_sel = 2'd1;
    add4 = 1'b1;
    goto(711);
    push(K_VAL, "sp1_add4", 'h0300);
    push(K_EXP, "sp1_exp", 0);
    add4 = 1'b0;
    goto(712);
    rst1 = 1'b1;
    goto(713);
    push(K_VAL, "preset15", 'h0015);
    rst1 = 1'b0;

    goto(2199);
    push(K_VAL, "sp1_one", 'h0001);
    push(K_EXP, "sp1_one_exp", 0);
    goto(2200);
    push(K_VAL, "sp1_zero", 'h0000);
    push(K_EXP, "sp1_expired", 2);
    goto(2300);
    push(K_MARK, "mark", 0);
    goto(2310);
    push(K_DISP, "exp_lit", int'({4'b1101, 7'h40}));
    goto(2360);
    push(K_DISP, "exp_blank", 'h7FF);
    goto(2400);
    push(K_BLANK, "exp_blink", 50);

    goto(2410);
    rst1 = 1'b1;
    goto(2411);
    rst1 = 1'b0;
    push(K_VAL, "preset_again", 'h0015);
    goto(2999);
    push(K_VAL, "pre_strobe", 'h0010);
    add2 = 1'b1;
    goto(3000);
    push(K_VAL, "add_on_strobe", 'h0129);
    add2 = 1'b0;

    goto(3001);
    space_sel = 2'd2;
    add3 = 1'b1;
    push(K_VAL, "oor_val", 'h0000);
    goto(3002);
    add3 = 1'b0;
    push(K_EXP, "oor_exp", 0);
    goto(3003);
    push(K_DISP, "oor_disp", int'({4'b1011, 7'h40}));
    space_sel = 2'd1;
    push(K_VAL, "oor_drop", 'h0129);

    goto(3010);
    space_sel = 2'd0;
    for (int i = 0; i < 37; i++) begin
      goto(3010 + 2 * i);
      add4 = 1'b1;
      goto(3011 + 2 * i);
      add4 = 1'b0;
    end
    goto(3084);
    push(K_VAL, "saturate", 'h9999);
    add1 = 1'b1;
    goto(3085);
    push(K_VAL, "sat_add1", 'h9999);
    add1 = 1'b0;
    goto(3086);
    push(K_MARK, "mark", 0);
    goto(3101);
    push(K_VAL, "sat_dec", 'h9998);
    goto(3186);
    push(K_BLANK, "ok_steady", 0);

    goto(3190);
    #2;
    rst = 1'b0;
    push(K_VAL, "async_val", 'h0000);
    push(K_EXP, "async_exp", 3);
    push(K_DISP, "async_disp", 'h7FF);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    goto(2);
    add1 = 1'b1;
    goto(3);
    add1 = 1'b0;
    goto(99);
    push(K_VAL, "pre_first", 'h0060);
    goto(100);
    push(K_VAL, "first_strobe", 'h0059);
    goto(102);

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
